// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
//   fetch_state_t    : fetch FSM encoding (IDLE/FETCH/HOLD/DROP, 2 bits)
//   PC_INCR          : sequential PC step in bytes
//   START_PC_DEFAULT : default PC loaded at reset (4-byte aligned)
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] START_PC_DEFAULT = 32'h0000_0040;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC selection for the fetch unit.
//   i_fetch_pc        : current fetch PC
//   i_redirect_valid  : taken branch / jump resolved at execute
//   i_redirect_target : redirect destination (may be misaligned)
//   o_pc_incr         : i_fetch_pc + 4, modulo 2^DBITS
//   o_next_pc         : word-aligned redirect target when redirecting, else o_pc_incr
//   o_misalign        : redirect this cycle with target[1:0] != 0
module fetch_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic [DBITS-1:0] i_fetch_pc,
    input  logic             i_redirect_valid,
    input  logic [DBITS-1:0] i_redirect_target,
    output logic [DBITS-1:0] o_pc_incr,
    output logic [DBITS-1:0] o_next_pc,
    output logic             o_misalign
);

    logic [DBITS-1:0] w_target_aligned;

    // Carry out of the top bit is dropped on purpose: the PC wraps silently.
    assign o_pc_incr        = i_fetch_pc + DBITS'(PC_INCR);
    assign w_target_aligned = {i_redirect_target[DBITS-1:2], 2'b00};
    assign o_next_pc        = i_redirect_valid ? w_target_aligned : o_pc_incr;
    assign o_misalign       = i_redirect_valid && (i_redirect_target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one instruction-memory read
// at a time and holds the fetched word in a one-entry buffer toward decode.
// Redirects from execute take priority over every other event and discard
// wrong-path work.
//   clk, reset_n        : clock (rising edge), async active-low reset
//   imem_req/imem_addr  : read request and byte address to instruction memory
//   imem_ack/imem_rdata : read completion and returned instruction
//   inst_valid/inst_ready, inst_word, inst_pc, inst_pc_plus4 : decode interface
//   redirect_valid/redirect_target : control-flow change from execute
//   misalign_err        : sticky flag, a redirect target had bits [1:0] != 0
//   dbg_state           : current fetch FSM state
//
// Handshake: inst_valid/inst_word/inst_pc/inst_pc_plus4 are held stable while
// inst_valid is high; a transfer happens on a rising edge where inst_valid and
// inst_ready are both high and redirect_valid is low (a redirect kills the held
// word, so decode must not count that edge). imem_req stays high with imem_addr
// stable until the cycle imem_ack is seen; an ack while imem_req is low is ignored.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               DBITS    = 32,
    parameter int               IBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = DBITS'(START_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [DBITS-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [IBITS-1:0] imem_rdata,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [IBITS-1:0] inst_word,
    output logic [DBITS-1:0] inst_pc,
    output logic [DBITS-1:0] inst_pc_plus4,
    input  logic             redirect_valid,
    input  logic [DBITS-1:0] redirect_target,
    output logic             misalign_err,
    output fetch_state_t     dbg_state
);

    fetch_state_t     r_state;
    logic [DBITS-1:0] r_fetch_pc;
    logic             r_imem_req;
    logic [DBITS-1:0] r_imem_addr;
    logic             r_inst_valid;
    logic [IBITS-1:0] r_inst_word;
    logic [DBITS-1:0] r_inst_pc;
    logic [DBITS-1:0] r_inst_pc_plus4;
    logic             r_misalign_err;

    logic [DBITS-1:0] w_pc_incr;
    logic [DBITS-1:0] w_next_pc;
    logic             w_misalign;

    fetch_pc_next #(.DBITS(DBITS)) u_pc_next (
        .i_fetch_pc        (r_fetch_pc),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .o_pc_incr         (w_pc_incr),
        .o_next_pc         (w_next_pc),
        .o_misalign        (w_misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_fetch_pc      <= START_PC;
            r_imem_req      <= 1'b0;
            r_imem_addr     <= START_PC;
            r_inst_valid    <= 1'b0;
            r_inst_word     <= '0;
            r_inst_pc       <= '0;
            r_inst_pc_plus4 <= '0;
            r_misalign_err  <= 1'b0;
        end else begin
            if (w_misalign) begin
                r_misalign_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state    <= ST_FETCH;
                    r_imem_req <= 1'b1;
                    if (redirect_valid) begin
                        r_fetch_pc  <= w_next_pc;
                        r_imem_addr <= w_next_pc;
                    end else begin
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                ST_FETCH: begin
                    if (!r_imem_req) begin
                        // One-cycle bubble after a discarded ack: issue now.
                        r_imem_req <= 1'b1;
                        if (redirect_valid) begin
                            r_fetch_pc  <= w_next_pc;
                            r_imem_addr <= w_next_pc;
                        end else begin
                            r_imem_addr <= r_fetch_pc;
                        end
                    end else if (redirect_valid) begin
                        r_fetch_pc <= w_next_pc;
                        if (imem_ack) begin
                            // Read finished on the wrong path: drop data, bubble.
                            r_imem_req <= 1'b0;
                        end else begin
                            // Read still in flight: leave it running, discard later.
                            r_state <= ST_DROP;
                        end
                    end else if (imem_ack) begin
                        r_inst_word     <= imem_rdata;
                        r_inst_pc       <= r_fetch_pc;
                        r_inst_pc_plus4 <= w_pc_incr;
                        r_inst_valid    <= 1'b1;
                        r_imem_req      <= 1'b0;
                        r_fetch_pc      <= w_pc_incr;
                        r_state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        r_inst_valid <= 1'b0;
                        r_fetch_pc   <= w_next_pc;
                        r_imem_req   <= 1'b1;
                        r_imem_addr  <= w_next_pc;
                        r_state      <= ST_FETCH;
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_imem_req   <= 1'b1;
                        r_imem_addr  <= r_fetch_pc;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (redirect_valid) begin
                        r_fetch_pc <= w_next_pc;
                    end
                    if (imem_ack) begin
                        // Wrong-path data discarded; bubble re-issues at fetch_pc.
                        r_imem_req <= 1'b0;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req      = r_imem_req;
    assign imem_addr     = r_imem_addr;
    assign inst_valid    = r_inst_valid;
    assign inst_word     = r_inst_word;
    assign inst_pc       = r_inst_pc;
    assign inst_pc_plus4 = r_inst_pc_plus4;
    assign misalign_err  = r_misalign_err;
    assign dbg_state     = r_state;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the processor: owns the PC, issues instruction-memory reads and hands fetched instructions to decode.
- Consumes the control-flow outcome produced at the execute stage's ALU/condition-check output (taken branch or jump plus target) and redirects fetch, discarding wrong-path work.
- At most one memory read outstanding; one-entry holding buffer toward decode.

Parameters:
- DBITS, 32, address/data width.
- IBITS, 32, instruction width.
- START_PC, 32'h40, PC loaded at reset (must be 4-byte aligned).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  DBITS  byte address of the requested word.
- imem_ack  input  1  read complete; imem_rdata valid this cycle.
- imem_rdata  input  IBITS  returned instruction.
- inst_valid  output  1  inst_word/inst_pc valid toward decode.
- inst_ready  input  1  decode accepts this cycle.
- inst_word  output  IBITS  instruction.
- inst_pc  output  DBITS  PC of inst_word.
- inst_pc_plus4  output  DBITS  inst_pc + 4.
- redirect_valid  input  1  taken branch or jump resolved at execute.
- redirect_target  input  DBITS  new PC.
- misalign_err  output  1  sticky: some redirect_target had bits [1:0] != 0.

Behaviour:
- Reset (async, on reset_n low), all outputs registered:
  - state = IDLE; fetch_pc = START_PC.
  - imem_req = 0, imem_addr = START_PC.
  - inst_valid = 0, inst_word = 0, inst_pc = 0, inst_pc_plus4 = 0.
  - misalign_err = 0.
- States: IDLE, FETCH, HOLD, DROP.
  - IDLE: one cycle after reset release, go to FETCH with imem_req = 1, imem_addr = fetch_pc.
  - FETCH: imem_req held at 1 with imem_addr stable until imem_ack. imem_ack is only meaningful while imem_req = 1; an ack in any other state is ignored.
    - On ack: capture imem_rdata, inst_pc = fetch_pc, inst_pc_plus4 = fetch_pc + 4; set inst_valid; drop imem_req; fetch_pc = fetch_pc + 4; go to HOLD.
  - HOLD: inst_valid = 1, outputs stable until inst_ready.
    - On inst_ready: clear inst_valid; reissue the request next cycle at fetch_pc; go to FETCH.
    - Fetch-to-decode throughput is therefore 1 instruction per (ack latency + 2) cycles.
  - DROP: a wrong-path read is outstanding; wait for imem_ack, discard the data, then go to FETCH at fetch_pc (already the target).
- Redirect (redirect_valid = 1) has priority over every other event in the same cycle. fetch_pc = {redirect_target[DBITS-1:2], 2'b00}.
  - HOLD: kill the held instruction (inst_valid = 0 next cycle, even if inst_ready is also high; decode must not count that handshake) and go to FETCH.
  - FETCH, no ack this cycle: keep imem_req/imem_addr unchanged until ack; go to DROP.
  - FETCH, ack this cycle: discard the data, no inst_valid; go to FETCH at the target, with imem_req low for one cycle.
  - DROP: the newer target overwrites fetch_pc; stay in DROP.
  - IDLE: the target replaces START_PC.
- misalign_err: set when redirect_valid and redirect_target[1:0] != 0; cleared only by reset.
- Arithmetic: all PC adds are modulo 2^DBITS; 32'hFFFFFFFC + 4 wraps to 0 with no flag.
- Reset mid-operation: an outstanding request is abandoned. Memory must tolerate imem_req dropping without an ack.

Decomposition:
- Shared package:
  - fetch state enum (IDLE/FETCH/HOLD/DROP, 2 bits).
  - PC_INCR = 4.
  - START_PC default.
- One natural sub-module, fetch_pc_next: combinational next-PC select (increment vs aligned redirect target) plus the misalignment detect.
- The FSM and holding buffer stay in fetch_unit.

Test Plan:
- Reset release, memory acks the cycle after each request with rdata = 32'hA000_0000 + addr, inst_ready tied 1 -> requests at 0x40, 0x44, 0x48; decode sees inst_pc 0x40/0x44/0x48 with matching words, one instruction per 3 cycles.
- inst_ready held 0 for 5 cycles in HOLD -> inst_word/inst_pc stable, imem_req stays 0; after ready, the next request goes to pc + 4.
- Redirect to 0x100 while a request to 0x48 is waiting 3 cycles for ack -> imem_addr holds 0x48 until ack, the data is dropped, next request is 0x100; decode never sees 0x48.
- Redirect to 0x200 in the same cycle as ack, then again to 0x300 while in DROP -> no inst_valid for the wrong path; the first delivered inst_pc is the last target issued (0x200 in the first case, 0x300 in the second).
- Redirect to 0x1002 -> misalign_err rises and stays high; fetch is issued at 0x1000.
- Redirect to 32'hFFFF_FFFC, then sequential fetch -> next request at 0x0; assert reset_n low mid-request -> all outputs go to reset values immediately.
